vx_operand_collector: RTL
=========================

# vx_operand_collector

Parametrised banked-GPR operand collector, one instance per issue slot, between the scoreboard stage and the dispatch/execute stage. It accepts one instruction's source register indices, reads up to NUM_SRCS operands from a NUM_BANKS-way banked register file, and serialises reads that conflict on a bank. Writebacks take priority over reads on a bank. It presents the collected operands with a valid/ready handshake. It replaces the fixed three-source, single-bank slice with configurable source count, banking and metadata, and adds perf counters.

## Interface
- NUM_WARPS, 4, warps sharing the register file
- NUM_REGS, 32, architectural registers per warp; register 0 reads as zero
- NUM_SRCS, 3, source operands per instruction (1..4)
- NUM_BANKS, 2, register file banks (power of two, 1..NUM_SRCS)
- NUM_THREADS, 4, lanes per warp
- XLEN, 32, bits per lane
- META_W, 32, opaque instruction payload width passed through unchanged
- PERF_CTR_BITS, 44, perf counter width
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- in_valid / in_ready  input / output  1 / 1  issue handshake
- in_wid  input  log2(NUM_WARPS)  warp id
- in_rs  input  NUM_SRCS*log2(NUM_REGS)  source indices; source i is at slice i
- in_used  input  NUM_SRCS  source-used mask
- in_meta  input  META_W  passthrough payload
- wb_valid  input  1  writeback strobe; always accepted
- wb_wid, wb_rd  input  log2(NUM_WARPS), log2(NUM_REGS)  writeback target
- wb_mask  input  NUM_THREADS  per-lane write enable
- wb_data  input  NUM_THREADS*XLEN  writeback data
- out_valid / out_ready  output / input  1 / 1  operand handshake
- out_data  output  NUM_SRCS*NUM_THREADS*XLEN  collected operands; source i is at slice i
- out_wid, out_meta  output  log2(NUM_WARPS), META_W  captured copies of in_wid and in_meta
- perf_rf_reads, perf_rf_writes, perf_bank_stalls  output  PERF_CTR_BITS each  counters

## Operation
- Bank mapping: bank(wid, r) = (r + wid) mod NUM_BANKS. Each bank has one synchronous read port and one write port, with a one-cycle read latency.
- FSM states: IDLE, COLLECT, DRAIN, OUT.
- in_ready = (state==IDLE) || (state==OUT && out_ready).
- On accept, the block captures wid, rs, used and meta. A source is marked done at accept, with its operand slot zeroed, if it is unused or its index is 0.
  - If no sources remain pending, the next state is OUT.
  - Otherwise the next state is COLLECT.
- COLLECT: each cycle, pending sources are scanned in ascending index. A source issues a read if both hold:
  - its bank is not claimed by a lower-index source this cycle;
  - its bank is not being written this cycle (wb_valid && wb_rd!=0 && bank(wb_wid,wb_rd) matches).
- A source that issues is marked done. Its read data is latched into its operand slot on the following edge.
- When the last pending sources issue, the next state is DRAIN. DRAIN latches the final read data, and the next state is OUT.
- OUT: out_valid=1, and out_data, out_wid and out_meta are held stable until out_ready.
  - A handshake with in_valid high accepts the next instruction in the same cycle (back-to-back).
  - Otherwise the next state is IDLE.
- Writeback: lanes with wb_mask set are written at the edge. Writes to register 0 are dropped, and drops do not count as writes.
  - A read blocked by a write issues on a later cycle and returns the new value, so no bypass path exists.
  - Continuous writes to one bank can stall collection indefinitely; this is allowed.
- Counters:
  - perf_rf_reads increments by the number of reads issued per cycle.
  - perf_rf_writes increments by 1 per non-dropped writeback.
  - perf_bank_stalls increments by 1 per COLLECT cycle in which a pending source could not issue.
  - All counters wrap modulo 2^PERF_CTR_BITS.

## Timing
- Reset (reset low, asynchronous): the block enters IDLE.
  - out_valid=0, in_ready=1 (once reset is deasserted), out_data/out_wid/out_meta=0, all counters 0.
  - Register file contents are not reset.
  - An assertion mid-transaction abandons it, and no output is produced.
- Latency from accept in cycle 0:
  - conflict-free with ≥1 read: issue in cycle 1, DRAIN in cycle 2, out_valid in cycle 3;
  - k serialised issue cycles: out_valid in cycle k+2;
  - no reads needed: out_valid in cycle 1.
- Throughput: one instruction per (latency) cycles. OUT overlaps with the next accept.
- Writeback accepted in cycle t is visible to any read issued in cycle t+1 or later.
- in_ready is combinational from state and out_ready. out_* are registered.

## Test plan
- Reset, then write r5 of warp 1 with all lanes = 0xA5A5A5A5, then issue wid=1, rs1=5, rs2=0, rs3 unused -> out_valid in cycle 3; src0 = 0xA5A5A5A5 on all lanes, src1=0, src2=0; perf_rf_reads=1, perf_rf_writes=1.
- NUM_BANKS=2, wid=0, rs=(2,4,6), all in bank 0 -> three issue cycles, out_valid in cycle 5, perf_bank_stalls=2.
- Conflict-free sources rs=(1,2,x) with wid=0, while holding wb_valid to bank(0,1) with wb_rd=3 for 2 cycles after accept -> rs1 is delayed 2 cycles, rs2 issues in cycle 1, and both values are correct.
- Write r7 of warp 0 in the same cycle r7 would issue -> read is blocked and returns the new data; with wb_mask=0b0101 only lanes 0 and 2 change.
- Hold out_ready=0 for 4 cycles, then out_ready=1 with in_valid=1 -> outputs stable while stalled; next instruction is accepted in the handshake cycle with no IDLE bubble.
- Drive reset low during COLLECT -> out_valid is 0 immediately and counters are 0; after release, in_ready=1 and a fresh transaction completes normally.

Source files
------------

// File: rtl/vx_operand_collector.sv
`default_nettype none
// ============================================================================
// Module      : vx_operand_collector
// Description : Per-issue-slot operand collector in front of a banked GPR file.
//               Captures one instruction's source indices and reads up to
//               NUM_SRCS operands. Reads that conflict on a bank are issued
//               one per cycle, and writebacks have priority on their bank.
//               The collected operands leave through a valid/ready handshake.
//               Perf counters track reads, writes and bank stalls.
// Revision    : 1.0  initial release
// ============================================================================
module vx_operand_collector #(
  parameter int NUM_WARPS     = 4,
  parameter int NUM_REGS      = 32,
  parameter int NUM_SRCS      = 3,
  parameter int NUM_BANKS     = 2,
  parameter int NUM_THREADS   = 4,
  parameter int XLEN          = 32,
  parameter int META_W        = 32,
  parameter int PERF_CTR_BITS = 44,
  localparam int WID_W  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int REG_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int LANE_W = NUM_THREADS * XLEN
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WID_W-1:0]             in_wid,
  input  logic [NUM_SRCS*REG_W-1:0]    in_rs,
  input  logic [NUM_SRCS-1:0]          in_used,
  input  logic [META_W-1:0]            in_meta,
  input  logic                         wb_valid,
  input  logic [WID_W-1:0]             wb_wid,
  input  logic [REG_W-1:0]             wb_rd,
  input  logic [NUM_THREADS-1:0]       wb_mask,
  input  logic [LANE_W-1:0]            wb_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_SRCS*LANE_W-1:0]   out_data,
  output logic [WID_W-1:0]             out_wid,
  output logic [META_W-1:0]            out_meta,
  output logic [PERF_CTR_BITS-1:0]     perf_rf_reads,
  output logic [PERF_CTR_BITS-1:0]     perf_rf_writes,
  output logic [PERF_CTR_BITS-1:0]     perf_bank_stalls
);

  localparam int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int BANK_DEPTH = (NUM_WARPS * NUM_REGS) / NUM_BANKS;
  localparam int ADDR_W     = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
  localparam int CNT_W      = $clog2(NUM_SRCS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    OUT     = 2'd3
  } state_t;

  // Registers of one warp rotate across the banks so that the same index in
  // neighbouring warps lands on different banks.
  function automatic logic [BANK_W-1:0] bank_of(input logic [WID_W-1:0] w,
                                                input logic [REG_W-1:0] r);
    return BANK_W'((int'(r) + int'(w)) % NUM_BANKS);
  endfunction

  // Within a bank, (wid, r / NUM_BANKS) uniquely identifies the entry.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [WID_W-1:0] w,
                                                input logic [REG_W-1:0] r);
    return ADDR_W'(int'(w) * (NUM_REGS / NUM_BANKS) + int'(r) / NUM_BANKS);
  endfunction

  state_t                 state, state_nxt;
  logic [WID_W-1:0]       cur_wid;
  logic [NUM_SRCS*REG_W-1:0] cur_rs;
  logic [META_W-1:0]      cur_meta;
  logic [NUM_SRCS-1:0]    done;
  logic [NUM_SRCS-1:0]    latch;
  logic [LANE_W-1:0]      opnd [NUM_SRCS];

  logic                   accept;
  logic [NUM_SRCS-1:0]    init_done;
  logic [BANK_W-1:0]      src_bank [NUM_SRCS];
  logic [ADDR_W-1:0]      src_addr [NUM_SRCS];
  logic [NUM_SRCS-1:0]    issue;
  logic [NUM_BANKS-1:0]   claimed;
  logic [ADDR_W-1:0]      bank_raddr [NUM_BANKS];
  logic [LANE_W-1:0]      bank_rdata [NUM_BANKS];
  logic                   stall;
  logic [CNT_W-1:0]       n_issue;
  logic                   wb_act;
  logic [BANK_W-1:0]      wb_bank;
  logic [ADDR_W-1:0]      wb_addr;

  assign accept  = in_valid && in_ready;
  assign wb_act  = wb_valid && (wb_rd != '0);
  assign wb_bank = bank_of(wb_wid, wb_rd);
  assign wb_addr = addr_of(wb_wid, wb_rd);

  // Per-source bank/address of the captured instruction, and the sources that
  // need no read at all for the instruction being offered.
  always_comb begin
    for (int s = 0; s < NUM_SRCS; s++) begin
      src_bank[s]  = bank_of(cur_wid, cur_rs[s*REG_W +: REG_W]);
      src_addr[s]  = addr_of(cur_wid, cur_rs[s*REG_W +: REG_W]);
      init_done[s] = !in_used[s] || (in_rs[s*REG_W +: REG_W] == '0);
    end
  end

  // Fixed-priority bank arbitration: lowest pending source wins its bank,
  // and a bank being written this cycle serves no read.
  always_comb begin
    claimed = '0;
    issue   = '0;
    stall   = 1'b0;
    n_issue = '0;
    for (int b = 0; b < NUM_BANKS; b++) bank_raddr[b] = '0;
    for (int s = 0; s < NUM_SRCS; s++) begin
      if (state == COLLECT && !done[s]) begin
        if (!claimed[src_bank[s]] && !(wb_act && wb_bank == src_bank[s])) begin
          issue[s]                = 1'b1;
          claimed[src_bank[s]]    = 1'b1;
          bank_raddr[src_bank[s]] = src_addr[s];
        end else begin
          stall = 1'b1;
        end
      end
      n_issue = n_issue + CNT_W'(issue[s]);
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [LANE_W-1:0] mem [BANK_DEPTH];
    logic [LANE_W-1:0] rdata_q;

    // One write port with per-lane enables and one synchronous read port.
    always_ff @(posedge clk) begin
      if (wb_act && wb_bank == BANK_W'(b)) begin
        for (int t = 0; t < NUM_THREADS; t++) begin
          if (wb_mask[t]) mem[wb_addr][t*XLEN +: XLEN] <= wb_data[t*XLEN +: XLEN];
        end
      end
      if (claimed[b]) rdata_q <= mem[bank_raddr[b]];
    end

    assign bank_rdata[b] = rdata_q;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and issue-side ready.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (&init_done) ? OUT : COLLECT;
      end
      COLLECT: begin
        if (&(done | issue)) state_nxt = DRAIN;
      end
      DRAIN: begin
        state_nxt = OUT;
      end
      OUT: begin
        if (out_ready) begin
          in_ready  = 1'b1;
          state_nxt = in_valid ? ((&init_done) ? OUT : COLLECT) : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Instruction capture, done tracking and operand latching one cycle after issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_wid  <= '0;
      cur_rs   <= '0;
      cur_meta <= '0;
      done     <= '0;
      latch    <= '0;
      for (int s = 0; s < NUM_SRCS; s++) opnd[s] <= '0;
    end else begin
      latch <= issue;
      if (accept) begin
        cur_wid  <= in_wid;
        cur_rs   <= in_rs;
        cur_meta <= in_meta;
        done     <= init_done;
        for (int s = 0; s < NUM_SRCS; s++) opnd[s] <= '0;
      end else begin
        done <= done | issue;
        for (int s = 0; s < NUM_SRCS; s++) begin
          if (latch[s]) opnd[s] <= bank_rdata[src_bank[s]];
        end
      end
    end
  end

  // Performance counters, free-running and wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_rf_reads    <= '0;
      perf_rf_writes   <= '0;
      perf_bank_stalls <= '0;
    end else begin
      perf_rf_reads <= perf_rf_reads + PERF_CTR_BITS'(n_issue);
      if (wb_act) perf_rf_writes   <= perf_rf_writes + 1'b1;
      if (stall)  perf_bank_stalls <= perf_bank_stalls + 1'b1;
    end
  end

  for (genvar s = 0; s < NUM_SRCS; s++) begin : g_out
    assign out_data[s*LANE_W +: LANE_W] = opnd[s];
  end

  assign out_valid = (state == OUT);
  assign out_wid   = cur_wid;
  assign out_meta  = cur_meta;

endmodule
`default_nettype wire
